// File: rtl/slot_round_ctrl.sv
// Round sequencer for the slot game: spin timing, reel-digit latch strobe,
// wildcard reel walk, payout handshake and the idle auto-roll timer.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for roll_pulse or auto-roll timer
// SPIN   | reels animating for SPIN_CYCLES unheld cycles
// LOAD   | one strobe: reels copy rng_digits, wildcard mask captured
// WAIT   | WILD_DELAY unheld cycles before the first wildcard goes live
// WILD   | reel wild_sel animates until stop_pulse locks it
// PAYOUT | payout_req held until payout_ack (ignores hold)
module slot_round_ctrl #(
  parameter int unsigned SPIN_CYCLES = 300000000,
  parameter int unsigned WILD_DELAY  = 50000000,
  parameter int unsigned AUTO_PERIOD = 100000000,
  parameter logic [3:0]  WILD_CODE   = 4'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        roll_pulse,
  input  logic        stop_pulse,
  input  logic        auto_en,
  input  logic        hold,
  input  logic [15:0] rng_digits,
  output logic        spinning,
  output logic        reel_load,
  output logic [3:0]  wild_mask,
  output logic [1:0]  wild_sel,
  output logic        wild_live,
  output logic        payout_req,
  input  logic        payout_ack,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SPIN   = 3'd1,
    S_LOAD   = 3'd2,
    S_WAIT   = 3'd3,
    S_WILD   = 3'd4,
    S_PAYOUT = 3'd5
  } state_t;

  localparam logic [31:0] SPIN_LAST = 32'(SPIN_CYCLES - 1);
  localparam logic [31:0] WILD_LAST = 32'(WILD_DELAY - 1);
  localparam logic [31:0] AUTO_LAST = 32'(AUTO_PERIOD - 1);

  state_t      state_q, state_d;
  logic [31:0] auto_cnt_q, auto_cnt_d;
  logic [31:0] spin_cnt_q, spin_cnt_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  load_mask;
  logic [3:0]  mask_cleared;

  // Lower reels are already locked, so the lowest set bit is always the next one up.
  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    lowest_set = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) lowest_set = 2'(i);
    end
  endfunction

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      auto_cnt_q <= '0;
      spin_cnt_q <= '0;
      wait_cnt_q <= '0;
      mask_q     <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      auto_cnt_q <= auto_cnt_d;
      spin_cnt_q <= spin_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mask_q     <= mask_d;
      sel_q      <= sel_d;
    end
  end

  // Next-state and counter logic; hold freezes everything except PAYOUT.
  always_comb begin
    state_d    = state_q;
    auto_cnt_d = '0;
    spin_cnt_d = spin_cnt_q;
    wait_cnt_d = wait_cnt_q;
    mask_d     = mask_q;
    sel_d      = sel_q;

    load_mask = {rng_digits[15:12] == WILD_CODE, rng_digits[11:8] == WILD_CODE,
                 rng_digits[7:4]   == WILD_CODE, rng_digits[3:0]  == WILD_CODE};
    mask_cleared = mask_q & ~(4'b0001 << sel_q);

    case (state_q)
      S_IDLE: begin
        if (!hold) begin
          if (roll_pulse || (auto_en && auto_cnt_q == AUTO_LAST)) begin
            state_d    = S_SPIN;
            spin_cnt_d = '0;
          end else if (auto_en) begin
            auto_cnt_d = auto_cnt_q + 32'd1;
          end
        end
      end
      S_SPIN: begin
        if (!hold) begin
          if (spin_cnt_q == SPIN_LAST) state_d = S_LOAD;
          else spin_cnt_d = spin_cnt_q + 32'd1;
        end
      end
      S_LOAD: begin
        if (!hold) begin
          mask_d     = load_mask;
          wait_cnt_d = '0;
          state_d    = (|load_mask) ? S_WAIT : S_PAYOUT;
        end
      end
      S_WAIT: begin
        if (!hold) begin
          if (wait_cnt_q == WILD_LAST) begin
            state_d = S_WILD;
            sel_d   = lowest_set(mask_q);
          end else begin
            wait_cnt_d = wait_cnt_q + 32'd1;
          end
        end
      end
      S_WILD: begin
        if (!hold && stop_pulse) begin
          mask_d = mask_cleared;
          if (mask_cleared == 4'd0) state_d = S_PAYOUT;
          else sel_d = lowest_set(mask_cleared);
        end
      end
      S_PAYOUT: begin
        if (payout_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    spinning   = (state_q == S_SPIN);
    reel_load  = (state_q == S_LOAD);
    wild_live  = (state_q == S_WILD);
    payout_req = (state_q == S_PAYOUT);
    busy       = (state_q != S_IDLE);
    wild_mask  = mask_q;
    wild_sel   = sel_q;
    state_dbg  = state_q;
  end

endmodule

// File: tb/tb_slot_round_ctrl.sv
module tb_slot_round_ctrl;
  localparam int SPIN_CYCLES = 8;
  localparam int WILD_DELAY  = 4;
  localparam int AUTO_PERIOD = 16;
  localparam int WILD_CODE   = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        roll_pulse = 1'b0, stop_pulse = 1'b0, auto_en = 1'b0, hold = 1'b0;
  logic        payout_ack = 1'b0;
  logic [15:0] rng_digits = 16'h0;
  logic        spinning, reel_load, wild_live, payout_req, busy;
  logic [3:0]  wild_mask;
  logic [1:0]  wild_sel;
  logic [2:0]  state_dbg;

  slot_round_ctrl #(
    .SPIN_CYCLES(SPIN_CYCLES), .WILD_DELAY(WILD_DELAY),
    .AUTO_PERIOD(AUTO_PERIOD), .WILD_CODE(4'(WILD_CODE))
  ) dut (
    .clk(clk), .rst(rst), .roll_pulse(roll_pulse), .stop_pulse(stop_pulse),
    .auto_en(auto_en), .hold(hold), .rng_digits(rng_digits),
    .spinning(spinning), .reel_load(reel_load), .wild_mask(wild_mask),
    .wild_sel(wild_sel), .wild_live(wild_live), .payout_req(payout_req),
    .payout_ack(payout_ack), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase number, cycles left in the timed phase, reel lock list.
  int         m_phase = 0;
  int         m_left  = 0;
  int         m_idle  = 0;
  logic [3:0] m_mask  = 4'h0;
  int         m_sel   = 0;
  int         m_pay_entries = 0;
  int         dut_pay_rises = 0;
  logic       prev_req = 1'b0;

  function automatic int lowest(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_phase = 0; m_left = 0; m_idle = 0; m_mask = 4'h0; m_sel = 0;
    end else begin
      case (m_phase)
        0: begin
          if (hold) m_idle = 0;
          else if (roll_pulse || (auto_en && m_idle == AUTO_PERIOD - 1)) begin
            m_phase = 1; m_left = SPIN_CYCLES; m_idle = 0;
          end else m_idle = auto_en ? m_idle + 1 : 0;
        end
        1: if (!hold) begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        2: if (!hold) begin
          for (int i = 0; i < 4; i++) m_mask[i] = (int'(rng_digits[4*i +: 4]) == WILD_CODE);
          if (m_mask != 0) begin m_phase = 3; m_left = WILD_DELAY; end
          else begin m_phase = 5; m_pay_entries++; end
        end
        3: if (!hold) begin
          m_left--;
          if (m_left == 0) begin m_phase = 4; m_sel = lowest(m_mask); end
        end
        4: if (!hold && stop_pulse) begin
          m_mask[m_sel] = 1'b0;
          if (m_mask == 0) begin m_phase = 5; m_pay_entries++; end
          else m_sel = lowest(m_mask);
        end
        5: if (payout_ack) begin m_phase = 0; m_idle = 0; end
        default: m_phase = 0;
      endcase
    end
  end

  // Compare DUT against model every cycle, half a period after the active edge.
  initial forever begin
    @(negedge clk);
    if (payout_req && !prev_req) dut_pay_rises++;
    prev_req = payout_req;
    if (cmp_en) begin
      chk("state_dbg",  state_dbg,  m_phase);
      chk("spinning",   spinning,   m_phase == 1);
      chk("reel_load",  reel_load,  m_phase == 2);
      chk("wild_live",  wild_live,  m_phase == 4);
      chk("payout_req", payout_req, m_phase == 5);
      chk("busy",       busy,       m_phase != 0);
      chk("wild_mask",  wild_mask,  m_mask);
      if (m_phase == 4) chk("wild_sel", wild_sel, m_sel);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_roll();
    roll_pulse = 1'b1; tick(); roll_pulse = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_pulse = 1'b1; tick(); stop_pulse = 1'b0;
  endtask

  task automatic finish_round();
    for (int i = 0; i < 200 && !payout_req; i++) tick();
    chk("payout_seen", payout_req, 1);
    payout_ack = 1'b1; tick(); payout_ack = 1'b0;
    chk("idle_after_ack", busy, 0);
  endtask

  int n;

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("reset_state", state_dbg, 0);
    chk("reset_mask", wild_mask, 0);

    // Plain round, no wildcards.
    rng_digits = 16'h1234;
    pulse_roll();
    n = 0;
    while (spinning && n < 100) begin n++; tick(); end
    chk("spin_len", n, 8);
    chk("load_strobe", reel_load, 1);
    tick();
    chk("payout_rise", payout_req, 1);
    chk("mask_nowild", wild_mask, 0);
    repeat (2) tick();
    payout_ack = 1'b1; tick(); payout_ack = 1'b0;
    chk("busy_after_ack", busy, 0);

    // Two wildcards on reels 1 and 3.
    rng_digits = 16'hA3A1;
    pulse_roll();
    for (int i = 0; i < 100 && !reel_load; i++) tick();
    tick();
    n = 0;
    while (state_dbg == 3'd3 && n < 100) begin n++; tick(); end
    chk("wait_len", n, 4);
    chk("wild_live1", wild_live, 1);
    chk("wild_sel1", wild_sel, 1);
    chk("wild_mask1", wild_mask, 4'b1010);
    pulse_stop();
    chk("wild_sel2", wild_sel, 3);
    chk("wild_mask2", wild_mask, 4'b1000);
    pulse_stop();
    chk("wild_mask3", wild_mask, 0);
    chk("payout_state", state_dbg, 5);
    payout_ack = 1'b1; tick(); payout_ack = 1'b0;

    // Auto-roll period, then with a hold interruption.
    rng_digits = 16'h1234;
    auto_en = 1'b1;
    n = 0;
    while (!busy && n < 100) begin n++; tick(); end
    chk("auto_period", n, 16);
    auto_en = 1'b0;
    finish_round();
    auto_en = 1'b1;
    repeat (10) tick();
    hold = 1'b1; repeat (5) tick(); hold = 1'b0;
    n = 0;
    while (!busy && n < 100) begin n++; tick(); end
    chk("auto_after_hold", n, 16);
    auto_en = 1'b0;
    finish_round();

    // Hold mid-spin at count 3.
    pulse_roll();
    repeat (3) tick();
    hold = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (spinning) n++; end
    chk("spin_held", n, 20);
    hold = 1'b0;
    n = 0;
    while (!reel_load && n < 100) begin n++; tick(); end
    chk("spin_remaining", n, 5);
    finish_round();

    // Reset while a wildcard is live; pulses in the reset cycle are ignored.
    rng_digits = 16'h0A00;
    pulse_roll();
    for (int i = 0; i < 100 && !wild_live; i++) tick();
    chk("wild_mask_r", wild_mask, 4'b0100);
    rst = 1'b1; roll_pulse = 1'b1; stop_pulse = 1'b1; payout_ack = 1'b1;
    tick();
    rst = 1'b0; roll_pulse = 1'b0; stop_pulse = 1'b0; payout_ack = 1'b0;
    chk("rst_state", state_dbg, 0);
    chk("rst_mask", wild_mask, 0);
    chk("rst_sel", wild_sel, 0);
    tick();
    chk("rst_stays_idle", busy, 0);

    // Ignored pulses: stop in IDLE, roll during SPIN.
    pulse_stop();
    chk("stop_idle", state_dbg, 0);
    rng_digits = 16'h5678;
    pulse_roll();
    repeat (3) tick();
    pulse_roll();
    chk("roll_in_spin", state_dbg, 1);
    finish_round();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      roll_pulse = ($urandom_range(0, 9) == 0);
      stop_pulse = ($urandom_range(0, 3) == 0);
      payout_ack = ($urandom_range(0, 2) == 0);
      if (hold) hold = ($urandom_range(0, 3) != 0);
      else      hold = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 99) == 0) auto_en = ~auto_en;
      rst = ($urandom_range(0, 599) == 0);
      for (int d = 0; d < 4; d++)
        rng_digits[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'(WILD_CODE) : 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; roll_pulse = 1'b0; stop_pulse = 1'b0; payout_ack = 1'b0; hold = 1'b0;
    tick();
    cmp_en = 1'b0;
    chk("payout_once", dut_pay_rises, m_pay_entries);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/slot_round_ctrl.md
Name: slot_round_ctrl

Overview:
- Round sequencer for the slot datapath: decides when a roll starts, how long the reels spin, when RNG digits are latched, which wildcard reel is live, and when the payout unit settles the bet.
- Owns every timing counter formerly embedded in the game top; reel-digit registers, balance arithmetic and display stay in their own blocks and follow this block's strobes.

Parameters:
SPIN_CYCLES, 300000000, cycles spent in SPIN before digits are latched
WILD_DELAY, 50000000, cycles from latch to first wildcard reel going live
AUTO_PERIOD, 100000000, idle cycles before an auto-roll fires
WILD_CODE, 10, RNG digit value marking a wildcard reel

Ports:
clk  in  1  100 MHz system clock
rst  in  1  synchronous active-high reset
roll_pulse  in  1  one-cycle roll request (edge-detected upstream)
stop_pulse  in  1  one-cycle wildcard lock request
auto_en  in  1  auto-roll switch
hold  in  1  high while balance or bet mode is selected, or the game is over
rng_digits  in  16  {d3,d2,d1,d0}, each 4 bits, sampled on reel_load
spinning  out  1  high during SPIN; reel blocks animate all digits
reel_load  out  1  one-cycle strobe; reel blocks copy rng_digits
wild_mask  out  4  reels still awaiting lock, bit n = reel n
wild_sel  out  2  index of the live wildcard reel, valid while wild_live
wild_live  out  1  high in WILD; reel wild_sel animates
payout_req  out  1  held high until payout_ack
payout_ack  in  1  payout unit has updated balance
busy  out  1  state != IDLE
state_dbg  out  3  IDLE=0 SPIN=1 LOAD=2 WAIT=3 WILD=4 PAYOUT=5

Behaviour:
- Reset: state IDLE; all counters 0; spinning, reel_load, wild_live, payout_req, busy 0; wild_mask 0; wild_sel 0. rst overrides everything, including mid-round.
- hold=1 freezes state and all counters, except in PAYOUT, which always completes. Pulses arriving while hold=1 are dropped.
- Auto-roll counter runs only in IDLE with auto_en=1 and hold=0; otherwise it is cleared. It fires when the count equals AUTO_PERIOD-1; the counter then clears.
- IDLE -> SPIN on roll_pulse or auto-roll fire. Spin counter loads 0; spinning=1 from the next cycle. A roll_pulse in any state other than IDLE is ignored.
- SPIN: the counter increments each cycle. When it reaches SPIN_CYCLES-1, go to LOAD. spinning stays high for exactly SPIN_CYCLES cycles.
- LOAD (one cycle): reel_load=1. wild_mask <= bit n = (digit n == WILD_CODE). If any bit is set, go to WAIT; otherwise go to PAYOUT.
- WAIT: counts WILD_DELAY cycles, then goes to WILD with wild_sel = lowest set bit of wild_mask.
- WILD: wild_live=1. On stop_pulse, clear wild_mask[wild_sel]. If higher set bits remain, wild_sel moves to the lowest remaining set bit and the state stays WILD. If none remain, go to PAYOUT. Lower reels are never revisited.
- PAYOUT: payout_req=1 until payout_ack is sampled high. On that cycle payout_req drops and the state goes to IDLE; the auto-roll counter restarts from 0. An ack arriving in the same cycle the state is entered is honoured, giving a one-cycle PAYOUT.
- A stop_pulse outside WILD is ignored. Payout is issued exactly once per round.
- rng_digits values above WILD_CODE are not wildcards; the payout logic treats them as ordinary digits.

Test Plan (SPIN_CYCLES=8, WILD_DELAY=4, AUTO_PERIOD=16 unless stated):
- roll_pulse at cycle 0, rng=16'h1234 → spinning high for 8 cycles, then reel_load for 1 cycle with wild_mask=0. payout_req rises the next cycle; ack 3 cycles later → IDLE, busy=0.
- rng=16'hA3A1 (d3=10, d1=10) → after LOAD, 4 WAIT cycles, then wild_live with wild_sel=1 and wild_mask=4'b1010. stop_pulse → wild_sel=3, mask=4'b1000. stop_pulse → mask=0, PAYOUT.
- auto_en=1, idle → roll fires after 16 cycles. Toggle hold at cycle 10 for 5 cycles → the counter clears and fires 16 cycles after hold drops.
- hold asserted mid-SPIN at count 3 for 20 cycles → spinning stays high and the count freezes. The remaining 5 cycles complete after release.
- rst asserted in WILD with mask=4'b0100 → next cycle: all outputs at reset values. roll_pulse, stop_pulse and payout_ack pulsed during the rst cycle have no effect.
- roll_pulse during SPIN and stop_pulse in IDLE → no state change; exactly one payout_req per round.
